// File: rtl/clkdiv_pkg.sv
// Shared definitions for the divided-clock ratio switch.
// Holds the ratio-select encodings, the switch FSM state type and the
// helper that turns a ratio select into the counter wrap mask.
package clkdiv_pkg;

    // Ratio select encodings: period is 2^(sel+1) system clocks.
    localparam logic [1:0] SEL_DIV2  = 2'd0;
    localparam logic [1:0] SEL_DIV4  = 2'd1;
    localparam logic [1:0] SEL_DIV8  = 2'd2;
    localparam logic [1:0] SEL_DIV16 = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fsm_state_e;

    // Low sel+1 bits set: the counter value at the last cycle of a period.
    function automatic logic [3:0] wrap_mask(input logic [1:0] sel);
        logic [4:0] full;
        full = (5'd2 << sel) - 5'd1;
        return full[3:0];
    endfunction

endpackage

// File: rtl/div_ratio_switch_if.sv
// Control/status bundle of the divided-clock ratio switch.
//   en, load, sel_in      : driven by the controlling block (master)
//   busy, sel_cur, div_out,
//   tick_rise, tick_fall,
//   load_err              : driven by the divider (slave)
interface div_ratio_switch_if;

    logic       en;
    logic       load;
    logic [1:0] sel_in;
    logic       busy;
    logic [1:0] sel_cur;
    logic       div_out;
    logic       tick_rise;
    logic       tick_fall;
    logic       load_err;

    modport master (
        output en, load, sel_in,
        input  busy, sel_cur, div_out, tick_rise, tick_fall, load_err
    );

    modport slave (
        input  en, load, sel_in,
        output busy, sel_cur, div_out, tick_rise, tick_fall, load_err
    );

endinterface

// File: rtl/div_ratio_fsm.sv
// Ratio-change request tracker for div_ratio_switch.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : count enable; request state holds while low
//   load_i      : single-cycle request to change ratio
//   sel_i       : requested ratio select, captured on an accepted load
//   wrap_i      : enabled wrap cycle of the current period
//   apply_o     : the pending ratio takes effect at the end of this cycle
//   sel_pend_o  : captured ratio select
//   busy_o      : request pending (registered)
//   load_err_o  : sticky, a load arrived while busy
module div_ratio_fsm
    import clkdiv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [1:0] sel_i,
    input  logic       wrap_i,
    output logic       apply_o,
    output logic [1:0] sel_pend_o,
    output logic       busy_o,
    output logic       load_err_o
);

    fsm_state_e state_q;
    logic [1:0] sel_pend_q;
    logic       busy_q;
    logic       load_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            sel_pend_q <= SEL_DIV2;
            busy_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            // A second request cannot be queued; flag it and drop it.
            if (load_i && busy_q) begin
                load_err_q <= 1'b1;
            end
            if (en_i) begin
                unique case (state_q)
                    RUN: begin
                        // Accepted even on a wrap cycle; it then waits a full period.
                        if (load_i) begin
                            sel_pend_q <= sel_i;
                            state_q    <= PEND;
                            busy_q     <= 1'b1;
                        end
                    end
                    PEND: begin
                        if (wrap_i) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign apply_o    = (state_q == PEND) && wrap_i;
    assign sel_pend_o = sel_pend_q;
    assign busy_o     = busy_q;
    assign load_err_o = load_err_q;

endmodule

// File: rtl/div_ratio_switch.sv
// Programmable divided-clock generator (/2, /4, /8, /16, 50% duty).
// Ratio changes take effect only at the end of the current output period so
// no runt phase is produced. One-cycle rise/fall strobes are provided for use
// as clock enables.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of div_ratio_switch_if (en/load/sel_in in;
//                busy/sel_cur/div_out/tick_rise/tick_fall/load_err out)
module div_ratio_switch
    import clkdiv_pkg::*;
#(
    parameter logic [1:0] DEFAULT_SEL = SEL_DIV2
) (
    input  logic               clk,
    input  logic               rst_n,
    div_ratio_switch_if.slave  bus
);

    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_cur_q, sel_cur_d;
    logic       div_q, div_d;
    logic       tick_rise_q, tick_rise_d;
    logic       tick_fall_q, tick_fall_d;

    logic [3:0] mask_cur;
    logic       wrap;
    logic       apply;
    logic [1:0] sel_pend;
    logic       busy;
    logic       load_err;

    assign mask_cur = wrap_mask(sel_cur_q);
    assign wrap     = bus.en && ((cnt_q & mask_cur) == mask_cur);

    div_ratio_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (bus.en),
        .load_i     (bus.load),
        .sel_i      (bus.sel_in),
        .wrap_i     (wrap),
        .apply_o    (apply),
        .sel_pend_o (sel_pend),
        .busy_o     (busy),
        .load_err_o (load_err)
    );

    always_comb begin
        cnt_d       = cnt_q;
        sel_cur_d   = sel_cur_q;
        div_d       = div_q;
        tick_rise_d = 1'b0;
        tick_fall_d = 1'b0;
        if (bus.en) begin
            if (apply) begin
                sel_cur_d = sel_pend;
            end
            cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
            // Output bit follows the ratio in effect next cycle, so a switch
            // always starts the new period low.
            div_d       = cnt_d[sel_cur_d];
            tick_rise_d = div_d & ~div_q;
            tick_fall_d = ~div_d & div_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            sel_cur_q   <= DEFAULT_SEL;
            div_q       <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel_cur_q   <= sel_cur_d;
            div_q       <= div_d;
            tick_rise_q <= tick_rise_d;
            tick_fall_q <= tick_fall_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.sel_cur   = sel_cur_q;
    assign bus.div_out   = div_q;
    assign bus.tick_rise = tick_rise_q;
    assign bus.tick_fall = tick_fall_q;
    assign bus.load_err  = load_err;

endmodule
